// File: rtl/cpu_datapath_if.sv
// Control/data bus between the Simple RISC Machine controller and its datapath.
// The controller drives the control word and instruction/memory inputs; the datapath returns
// the decoded IR fields, the C register and the status flags.
interface cpu_datapath_if;
  logic [15:0] in;
  logic        load;
  logic [15:0] mdata;
  logic [7:0]  pc;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [2:0]  nsel;
  logic        write;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [15:0] datapath_out;
  logic        Z;
  logic        N;
  logic        V;

  modport master (
    output in, load, mdata, pc, loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write,
    input  opcode, op, datapath_out, Z, N, V
  );

  modport slave (
    input  in, load, mdata, pc, loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write,
    output opcode, op, datapath_out, Z, N, V
  );
endinterface

// File: rtl/cpu_datapath.sv
// Instruction register, 8x16 register file, shifter, ALU and A/B/C/status pipeline registers.
// Executes one control word per clock.
module cpu_datapath (
  input logic             clk,
  input logic             reset,
  cpu_datapath_if.slave   bus
);

  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        v_q, v_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  logic [2:0]  rn, rd, rm, readnum;
  logic [1:0]  shift, alu_op;
  logic [15:0] sximm8, sximm5;
  logic [15:0] rdata, b_shift, ain, bin, alu_res, wdata;
  logic        alu_v;

  // IR field decode
  always_comb begin
    rn     = ir_q[10:8];
    rd     = ir_q[7:5];
    shift  = ir_q[4:3];
    rm     = ir_q[2:0];
    alu_op = ir_q[12:11];
    sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    // Non-one-hot nsel ORs fields together; nsel=000 falls through to R0.
    readnum = ({3{bus.nsel[2]}} & rn) | ({3{bus.nsel[1]}} & rd) | ({3{bus.nsel[0]}} & rm);
    rdata   = regs_q[readnum];
  end

  // Shifter and ALU
  always_comb begin
    unique case (shift)
      2'b00:   b_shift = b_q;
      2'b01:   b_shift = {b_q[14:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[15:1]};
      default: b_shift = {b_q[15], b_q[15:1]};
    endcase

    ain = bus.asel ? 16'h0000 : a_q;
    bin = bus.bsel ? sximm5 : b_shift;

    alu_res = 16'h0000;
    alu_v   = 1'b0;
    unique case (alu_op)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[15] == bin[15]) && (alu_res[15] != ain[15]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[15] != bin[15]) && (alu_res[15] != ain[15]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  // Next-state
  always_comb begin
    unique case (bus.vsel)
      2'b00:   wdata = c_q;
      2'b01:   wdata = {8'b0, bus.pc};
      2'b10:   wdata = sximm8;
      default: wdata = bus.mdata;
    endcase

    ir_d = bus.load  ? bus.in : ir_q;
    a_d  = bus.loada ? rdata  : a_q;
    b_d  = bus.loadb ? rdata  : b_q;
    c_d  = bus.loadc ? alu_res : c_q;
    z_d  = z_q;
    n_d  = n_q;
    v_d  = v_q;
    if (bus.loads) begin
      z_d = (alu_res == 16'h0000);
      n_d = alu_res[15];
      v_d = alu_v;
    end

    regs_d = regs_q;
    if (bus.write) regs_d[readnum] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= 16'h0000;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
      c_q  <= 16'h0000;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      v_q  <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      ir_q <= ir_d;
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      z_q  <= z_d;
      n_q  <= n_d;
      v_q  <= v_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.opcode       = ir_q[15:13];
  assign bus.op           = ir_q[12:11];
  assign bus.datapath_out = c_q;
  assign bus.Z            = z_q;
  assign bus.N            = n_q;
  assign bus.V            = v_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath: short instruction sequences with hand-computed results.
module tb_cpu_datapath;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cpu_datapath_if bus ();

  cpu_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.load  = 1'b0;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    bus.asel  = 1'b0;
    bus.bsel  = 1'b0;
    bus.vsel  = 2'b00;
    bus.nsel  = 3'b000;
    bus.write = 1'b0;
  endtask

  // Apply the currently driven control word on one rising edge, then return controls to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_ir(input logic [15:0] instr);
    bus.in   = instr;
    bus.load = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] flags();
    return {13'b0, bus.Z, bus.N, bus.V};
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    bus.in    = 16'h0000;
    bus.mdata = 16'h0000;
    bus.pc    = 8'h00;
    idle();

    // 1. reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_out", bus.datapath_out, 16'h0000);
    check("rst_flags", flags(), 16'h0000);
    check("rst_opcode", {13'b0, bus.opcode}, 16'h0000);
    check("rst_op", {14'b0, bus.op}, 16'h0000);
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), dut.regs_q[i], 16'h0000);

    // 2. MOV R0,#7
    load_ir(16'hD007);
    check("mov_opcode", {13'b0, bus.opcode}, 16'h0006);
    check("mov_op", {14'b0, bus.op}, 16'h0002);
    bus.nsel = 3'b100; bus.vsel = 2'b10; bus.write = 1'b1;
    tick();
    check("mov_r0", dut.regs_q[0], 16'h0007);

    // 3. MOV R2,#-1 then MOV R6,R2 LSR#1
    load_ir(16'hD2FF);
    bus.nsel = 3'b100; bus.vsel = 2'b10; bus.write = 1'b1;
    tick();
    check("mov_r2", dut.regs_q[2], 16'hFFFF);
    load_ir(16'hC0D2);
    bus.nsel = 3'b001; bus.loadb = 1'b1;
    tick();
    bus.asel = 1'b1; bus.loadc = 1'b1;
    tick();
    bus.nsel = 3'b010; bus.vsel = 2'b00; bus.write = 1'b1;
    tick();
    check("lsr_r6", dut.regs_q[6], 16'h7FFF);
    check("lsr_out", bus.datapath_out, 16'h7FFF);

    // 4. ADD R7,R6,R0 overflows into the sign bit
    load_ir(16'hA6E0);
    bus.nsel = 3'b100; bus.loada = 1'b1;
    tick();
    bus.nsel = 3'b001; bus.loadb = 1'b1;
    tick();
    bus.loadc = 1'b1; bus.loads = 1'b1;
    tick();
    bus.nsel = 3'b010; bus.vsel = 2'b00; bus.write = 1'b1;
    tick();
    check("add_r7", dut.regs_q[7], 16'h8006);
    check("add_flags", flags(), 16'h0003);

    // 5. CMP R0,R0 touches status only
    load_ir(16'hA800);
    bus.nsel = 3'b100; bus.loada = 1'b1;
    tick();
    bus.nsel = 3'b001; bus.loadb = 1'b1;
    tick();
    bus.loads = 1'b1;
    tick();
    check("cmp_flags", flags(), 16'h0004);
    check("cmp_out_hold", bus.datapath_out, 16'h8006);

    // LSL#1 of R2 with asel; same-edge write-back of old C into R0; concurrent IR load
    load_ir(16'hA00A);
    bus.nsel = 3'b001; bus.loadb = 1'b1;
    tick();
    bus.asel = 1'b1; bus.loadc = 1'b1;
    bus.nsel = 3'b010; bus.vsel = 2'b00; bus.write = 1'b1;
    bus.in = 16'hB81A; bus.load = 1'b1;
    tick();
    check("lsl_out_old_ir", bus.datapath_out, 16'hFFFE);
    check("wb_old_c", dut.regs_q[0], 16'h8006);
    check("new_op", {14'b0, bus.op}, 16'h0003);

    // MVN of R2 ASR#1
    bus.nsel = 3'b001; bus.loadb = 1'b1;
    tick();
    bus.loadc = 1'b1; bus.loads = 1'b1;
    tick();
    check("mvn_out", bus.datapath_out, 16'h0000);
    check("mvn_flags", flags(), 16'h0004);

    // AND R2 with sximm5 (0x15 -> 0xFFF5)
    load_ir(16'hB215);
    bus.nsel = 3'b100; bus.loada = 1'b1;
    tick();
    bus.bsel = 1'b1; bus.loadc = 1'b1; bus.loads = 1'b1;
    tick();
    check("and_out", bus.datapath_out, 16'hFFF5);
    check("and_flags", flags(), 16'h0002);

    // Write-back from pc and mdata into R1, then read and write R1 on the same edge
    load_ir(16'hA820);
    bus.pc = 8'h5A; bus.nsel = 3'b010; bus.vsel = 2'b01; bus.write = 1'b1;
    tick();
    check("wb_pc", dut.regs_q[1], 16'h005A);
    bus.mdata = 16'h1234; bus.nsel = 3'b010; bus.vsel = 2'b11; bus.write = 1'b1;
    tick();
    check("wb_mdata", dut.regs_q[1], 16'h1234);
    bus.nsel = 3'b010; bus.loada = 1'b1; bus.vsel = 2'b10; bus.write = 1'b1;
    tick();
    check("rw_a_old", dut.a_q, 16'h1234);
    check("rw_r1_new", dut.regs_q[1], 16'h0020);

    // 6. Reset right after loada of R6, with a write and loadc pending on that edge
    load_ir(16'hA6E0);
    bus.nsel = 3'b100; bus.loada = 1'b1;
    tick();
    check("pre_rst_a", dut.a_q, 16'h7FFF);
    reset = 1'b1;
    bus.nsel = 3'b010; bus.vsel = 2'b10; bus.write = 1'b1; bus.loadc = 1'b1; bus.loads = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_a", dut.a_q, 16'h0000);
    check("mid_rst_out", bus.datapath_out, 16'h0000);
    check("mid_rst_flags", flags(), 16'h0000);
    check("mid_rst_r6", dut.regs_q[6], 16'h0000);
    check("mid_rst_r7", dut.regs_q[7], 16'h0000);
    check("mid_rst_opcode", {13'b0, bus.opcode}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
